// File: rtl/branch_pred_ctrl.sv
// Branch prediction / EX-resolve unit: direct-mapped 2-bit counters plus a tagged BTB.
// Optional BRANCH_PRED_STATS_EN adds resolved-branch and mispredict counters.
module branch_pred_entry #(
  parameter int         ADDR_W   = 32,
  parameter int         TAG_BITS = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cnt_we,
  input  logic                cnt_up,
  input  logic                btb_set,
  input  logic                btb_clr,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [ADDR_W-1:0]   wr_target,
  output logic [1:0]          cnt,
  output logic                btb_valid,
  output logic [TAG_BITS-1:0] btb_tag,
  output logic [ADDR_W-1:0]   btb_target
);
  // Tag and target are reset too, so an aborted write never leaves a half-formed entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= CNT_INIT;
      btb_valid  <= 1'b0;
      btb_tag    <= '0;
      btb_target <= '0;
    end else begin
      if (cnt_we) begin
        if (cnt_up && cnt != 2'b11)       cnt <= cnt + 2'd1;
        else if (!cnt_up && cnt != 2'b00) cnt <= cnt - 2'd1;
      end
      if (btb_set) begin
        btb_valid  <= 1'b1;
        btb_tag    <= wr_tag;
        btb_target <= wr_target;
      end else if (btb_clr) begin
        btb_valid  <= 1'b0;
      end
    end
  end
endmodule

module branch_pred_ctrl #(
  parameter int         ADDR_W   = 32,
  parameter int         IDX_BITS = 6,
  parameter int         TAG_BITS = 8,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_next_pc,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);
  localparam int NENT = 1 << IDX_BITS;

  logic [NENT-1:0][1:0]          cnt_q;
  logic [NENT-1:0]               vld_q;
  logic [NENT-1:0][TAG_BITS-1:0] tag_q;
  logic [NENT-1:0][ADDR_W-1:0]   tgt_q;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic [ADDR_W-1:0]   if_pc4, ex_pc4, actual_next;
  logic                hit, train_br, train_set, train_clr;
  logic                unused_pc;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign if_pc4 = if_pc + ADDR_W'(4);
  assign ex_pc4 = ex_pc + ADDR_W'(4);
  assign unused_pc = ^{if_pc, ex_pc};

  // Predict from registered state only: a same-cycle write is seen next cycle.
  assign hit          = vld_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken   = hit && cnt_q[if_idx][1];
  assign pred_next_pc = pred_taken ? tgt_q[if_idx] : if_pc4;

  assign actual_next = ex_taken ? ex_target : ex_pc4;

  always_comb begin
    flush       = 1'b0;
    redirect_pc = ex_pc4;
    if (ex_valid) begin
      if (ex_is_branch) begin
        redirect_pc = actual_next;
        flush       = (actual_next != ex_pred_next_pc);
      end else if (ex_pred_taken) begin
        flush = 1'b1;
      end
    end
  end

  assign train_br  = ex_valid && ex_is_branch;
  assign train_set = train_br && ex_taken;
  // A non-branch that hit the BTB is an alias: drop the entry, keep the counter.
  assign train_clr = ex_valid && !ex_is_branch && ex_pred_taken;

  for (genvar i = 0; i < NENT; i++) begin : g_ent
    logic sel;
    assign sel = (ex_idx == IDX_BITS'(i));
    branch_pred_entry #(.ADDR_W(ADDR_W), .TAG_BITS(TAG_BITS), .CNT_INIT(CNT_INIT)) u_ent (
      .clk        (clk),
      .rst        (rst),
      .cnt_we     (train_br && sel),
      .cnt_up     (ex_taken),
      .btb_set    (train_set && sel),
      .btb_clr    (train_clr && sel),
      .wr_tag     (ex_tag),
      .wr_target  (ex_target),
      .cnt        (cnt_q[i]),
      .btb_valid  (vld_q[i]),
      .btb_tag    (tag_q[i]),
      .btb_target (tgt_q[i])
    );
  end

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] br_q, mp_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_q + 32'(train_br);
      mp_q <= mp_q + 32'(flush);
    end
  end
  assign stat_branches    = br_q;
  assign stat_mispredicts = mp_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Randomized + directed bench for branch_pred_ctrl against a table-level reference model.
module tb_branch_pred_ctrl;
  localparam int IDX  = 6;
  localparam int TAGB = 8;
  localparam int NENT = 1 << IDX;

  logic        clk, rst;
  logic [31:0] if_pc, ex_pc, ex_target, ex_pred_next_pc;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic        pred_taken, flush;
  logic [31:0] pred_next_pc, redirect_pc, stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  int          m_cnt [NENT];
  bit          m_vld [NENT];
  int          m_tag [NENT];
  logic [31:0] m_tgt [NENT];
  int          m_br, m_mp;

  branch_pred_ctrl #(.ADDR_W(32), .IDX_BITS(IDX), .TAG_BITS(TAGB), .CNT_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_next_pc(ex_pred_next_pc),
    .flush(flush), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction
  function automatic int tag_of(logic [31:0] pc);
    return int'((pc >> (IDX + 2)) % (1 << TAGB));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_cnt[i] = 1; m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_br = 0; m_mp = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output bit t, output logic [31:0] nxt);
    int i = idx_of(pc);
    t   = m_vld[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
    nxt = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_resolve(output bit f, output logic [31:0] r);
    logic [31:0] act;
    f = 0;
    r = ex_pc + 32'd4;
    if (ex_valid) begin
      if (ex_is_branch) begin
        act = ex_taken ? ex_target : ex_pc + 32'd4;
        f = (act != ex_pred_next_pc);
        r = act;
      end else if (ex_pred_taken) f = 1;
    end
  endtask

  // One clock edge; the model trains from the inputs held across the edge.
  task automatic tick();
    bit f; logic [31:0] r; int i;
    model_resolve(f, r);
    @(posedge clk);
    if (rst) begin
      i = idx_of(ex_pc);
      if (ex_valid && ex_is_branch) begin
        m_br++;
        if (ex_taken) begin
          if (m_cnt[i] < 3) m_cnt[i]++;
          m_vld[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target;
        end else if (m_cnt[i] > 0) m_cnt[i]--;
      end else if (ex_valid && ex_pred_taken) m_vld[i] = 0;
      if (f) m_mp++;
    end
    #1;
  endtask

  task automatic set_ex(input bit v, input bit br, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit pt, input logic [31:0] pn);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_next_pc = pn;
  endtask

  task automatic test_reset();
    rst = 0; if_pc = 32'h100;
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    model_reset();
    #2;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
    checks++; if (pred_next_pc !== 32'h104) begin errors++; $display("FAIL reset_next_pc got %h want 00000104", pred_next_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", flush); end
    checks++; if (stat_branches !== 0 || stat_mispredicts !== 0) begin errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
    tick(); tick();
    @(negedge clk); rst = 1; #1;
  endtask

  task automatic test_cold_taken();
    set_ex(1, 1, 32'h40, 1, 32'h80, 0, 32'h44); if_pc = 32'h40;
    #2;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL cold_flush got %0b want 1", flush); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL cold_redirect got %h want 00000080", redirect_pc); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL cold_same_cycle_pred got %0b want 0", pred_taken); end
    tick();
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    #2;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL cold_trained_pred got %0b want 1", pred_taken); end
    checks++; if (pred_next_pc !== 32'h80) begin errors++; $display("FAIL cold_trained_next got %h want 00000080", pred_next_pc); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      set_ex(1, 1, 32'h40, 1, 32'h80, 1, 32'h80); #2;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL sat_taken_flush[%0d] got %0b want 0", k, flush); end
      tick();
    end
    set_ex(1, 1, 32'h40, 0, 32'h80, 1, 32'h80); if_pc = 32'h40; #2;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h44) begin errors++; $display("FAIL sat_nt_flush got %0b/%h want 1/00000044", flush, redirect_pc); end
    tick();
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0); #2;
    checks++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80) begin errors++; $display("FAIL sat_still_taken got %0b/%h want 1/00000080", pred_taken, pred_next_pc); end
  endtask

  task automatic test_tag_alias();
    if_pc = 32'h40 + (32'd1 << (IDX + 2)); #2;
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== if_pc + 32'd4) begin errors++; $display("FAIL alias_miss got %0b/%h want 0/%h", pred_taken, pred_next_pc, if_pc + 32'd4); end
  endtask

  task automatic test_nonbranch();
    set_ex(1, 0, 32'h40, 0, 32'h0, 1, 32'h80); if_pc = 32'h40; #2;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h44) begin errors++; $display("FAIL nonbr_flush got %0b/%h want 1/00000044", flush, redirect_pc); end
    tick();
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0); #2;
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h44) begin errors++; $display("FAIL nonbr_cleared got %0b/%h want 0/00000044", pred_taken, pred_next_pc); end
  endtask

  task automatic test_bubble();
    set_ex(0, 1, 32'h200, 1, 32'h300, 1, 32'h999); if_pc = 32'h200; #2;
    checks++; if (flush !== 1'b0 || redirect_pc !== 32'h204) begin errors++; $display("FAIL bubble_flush got %0b/%h want 0/00000204", flush, redirect_pc); end
    tick(); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL bubble_no_train got %0b want 0", pred_taken); end
    set_ex(1, 1, 32'h200, 0, 32'h300, 0, 32'h204); #2;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL extra_branch_flush got %0b want 0", flush); end
    tick();
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0); #1;
`ifdef BRANCH_PRED_STATS_EN
    checks++; if (stat_branches !== 32'd7 || stat_mispredicts !== 32'd3) begin errors++; $display("FAIL stats_directed got %0d/%0d want 7/3", stat_branches, stat_mispredicts); end
`else
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin errors++; $display("FAIL stats_tied got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
`endif
  endtask

  task automatic test_random();
    logic [31:0] pool [6] = '{32'h40, 32'h44, 32'h140, 32'h1040, 32'hFFFF_FFFC, 32'h7C};
    bit et, pt; logic [31:0] en, pn, rr; bit ef;
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      set_ex($urandom_range(0, 9) != 0, ($urandom % 4) != 0, pool[$urandom_range(0, 5)],
             $urandom % 2, $urandom & 32'hFFFF_FFFC, 0, 32'h0);
      model_predict(ex_pc, pt, pn);
      if ($urandom_range(0, 7) == 0) begin pt = $urandom % 2; pn = $urandom & 32'hFFFF_FFFC; end
      ex_pred_taken = pt; ex_pred_next_pc = pn;
      if_pc = pool[$urandom_range(0, 5)];
      #2;
      model_predict(if_pc, et, en);
      model_resolve(ef, rr);
      checks++;
      if (pred_taken !== et || pred_next_pc !== en || flush !== ef || redirect_pc !== rr) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rand[%0d] pred %0b/%h flush %0b/%h want %0b/%h %0b/%h",
          n, pred_taken, pred_next_pc, flush, redirect_pc, et, en, ef, rr);
      end
      tick();
    end
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0); #1;
`ifdef BRANCH_PRED_STATS_EN
    checks++; if (stat_branches !== 32'(m_br) || stat_mispredicts !== 32'(m_mp)) begin errors++; $display("FAIL stats_random got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_br, m_mp); end
`else
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin errors++; $display("FAIL stats_random_tied got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
`endif
  endtask

  task automatic test_async_reset();
    set_ex(1, 1, 32'h40, 1, 32'h500, 0, 32'h44); tick();
    set_ex(1, 1, 32'h40, 1, 32'h500, 1, 32'h500); if_pc = 32'h40; #2;
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_pred got %0b want 1", pred_taken); end
    rst = 0; #1;
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h44) begin errors++; $display("FAIL async_reset_pred got %0b/%h want 0/00000044", pred_taken, pred_next_pc); end
    checks++; if (stat_branches !== 0 || stat_mispredicts !== 0) begin errors++; $display("FAIL async_reset_stats got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
    model_reset();
    @(posedge clk); #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_held_train got %0b want 0", pred_taken); end
    @(negedge clk); rst = 1;
    set_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    tick(); #1;
    checks++; if (pred_taken !== 1'b0 || pred_next_pc !== 32'h44) begin errors++; $display("FAIL post_reset_pred got %0b/%h want 0/00000044", pred_taken, pred_next_pc); end
  endtask

  initial begin
    test_reset();
    test_cold_taken();
    test_saturation();
    test_tag_alias();
    test_nonbranch();
    test_bubble();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
